// File: rtl/spike_mon_pkg.sv
// spike_mon_pkg: shared states, default width and saturation helper for the spike window monitor
package spike_mon_pkg;
  localparam int CNT_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;
  function automatic int sat_of(input int w);
    return (1 << w) - 1;
  endfunction
  localparam int SAT_DEF = sat_of(CNT_W_DEF);
endpackage

// File: rtl/spike_window_monitor_if.sv
// spike_window_monitor_if: control, spike input and result handshake of the spike window monitor
interface spike_window_monitor_if
  import spike_mon_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             ena;
  logic             spike_in;
  logic [CNT_W-1:0] win_len;
  logic             start;
  logic             res_ready;
  logic             res_valid;
  logic [CNT_W-1:0] spike_cnt;
  logic [CNT_W-1:0] isi_min;
  logic             busy;
  modport master (output ena, spike_in, win_len, start, res_ready,
                  input res_valid, spike_cnt, isi_min, busy);
  modport slave  (input ena, spike_in, win_len, start, res_ready,
                  output res_valid, spike_cnt, isi_min, busy);
endinterface

// File: rtl/spike_edge_det.sv
// spike_edge_det: rising-edge detector with enable and synchronous clear of the history bit
module spike_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic d,
  output logic rise
);
  logic prev_q, prev_d;
  always_comb prev_d = clr ? 1'b0 : en ? d : prev_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  assign rise = d & ~prev_q;
endmodule

// File: rtl/spike_window_monitor.sv
// spike_window_monitor: counts spike rising edges and minimum inter-spike interval over a window
module spike_window_monitor
  import spike_mon_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input logic                    clk,
  input logic                    rst_n,
  spike_window_monitor_if.slave  bus
);
  localparam logic [CNT_W-1:0] SAT = CNT_W'(sat_of(CNT_W));
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d, cnt_q, cnt_d, isi_q, isi_d, gap_q, gap_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d, out_isi_q, out_isi_d;
  logic seen_q, seen_d, valid_q, valid_d;
  logic go, adv, rise, hit;
  assign go  = bus.ena && state_q == IDLE && bus.start;
  assign adv = bus.ena && state_q == COUNT;
  assign hit = adv && rise;
  spike_edge_det u_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (adv),
    .clr  (go),
    .d    (bus.spike_in),
    .rise (rise)
  );
  // gap_q holds the distance from the last counted edge to the current cycle
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    isi_d     = isi_q;
    gap_d     = gap_q;
    seen_d    = seen_q;
    valid_d   = valid_q;
    out_cnt_d = out_cnt_q;
    out_isi_d = out_isi_q;
    if (go) begin
      state_d = COUNT;
      rem_d   = bus.win_len;
      cnt_d   = '0;
      isi_d   = SAT;
      gap_d   = '0;
      seen_d  = 1'b0;
    end
    if (adv) begin
      rem_d  = rem_q - ONE;
      cnt_d  = (hit && cnt_q != SAT) ? cnt_q + ONE : cnt_q;
      gap_d  = hit ? ONE : (gap_q != SAT ? gap_q + ONE : gap_q);
      seen_d = seen_q | hit;
      isi_d  = (hit && seen_q && gap_q < isi_q) ? gap_q : isi_q;
      if (rem_q == ONE) begin
        state_d   = HOLD;
        valid_d   = 1'b1;
        out_cnt_d = cnt_d;
        out_isi_d = isi_d;
      end
    end
    if (bus.ena && state_q == HOLD && bus.res_ready) begin
      state_d   = IDLE;
      valid_d   = 1'b0;
      out_cnt_d = '0;
      out_isi_d = SAT;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      cnt_q     <= '0;
      isi_q     <= SAT;
      gap_q     <= '0;
      seen_q    <= 1'b0;
      valid_q   <= 1'b0;
      out_cnt_q <= '0;
      out_isi_q <= SAT;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      isi_q     <= isi_d;
      gap_q     <= gap_d;
      seen_q    <= seen_d;
      valid_q   <= valid_d;
      out_cnt_q <= out_cnt_d;
      out_isi_q <= out_isi_d;
    end
  assign bus.res_valid = valid_q;
  assign bus.spike_cnt = out_cnt_q;
  assign bus.isi_min   = out_isi_q;
  assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_spike_window_monitor.sv
// tb_spike_window_monitor: directed windows checked against a sample-list model of the monitor
module tb_spike_window_monitor;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;

  spike_window_monitor_if #(.CNT_W(8)) bus ();
  spike_window_monitor #(.CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: 0 idle, 1 window open, 2 result held; the window is kept as the raw sample list
  int m_state = 0;
  int m_left = 0;
  int m_cnt = 0;
  int m_isi = 255;
  bit m_samp[$];

  task automatic model_eval();
    int last_e = -1;
    int n = 0;
    int mi = 255;
    bit prev = 1'b0;
    foreach (m_samp[i]) begin
      if (m_samp[i] && !prev) begin
        if (last_e >= 0 && i - last_e < mi) mi = i - last_e;
        last_e = i;
        n++;
      end
      prev = m_samp[i];
    end
    m_cnt = n > 255 ? 255 : n;
    m_isi = mi;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0;
      m_cnt = 0;
      m_isi = 255;
      m_samp.delete();
    end else if (bus.ena) begin
      if (m_state == 0 && bus.start) begin
        m_state = 1;
        m_left = bus.win_len == 0 ? 256 : int'(bus.win_len);
        m_samp.delete();
      end else if (m_state == 1) begin
        m_samp.push_back(bus.spike_in);
        m_left--;
        if (m_left == 0) begin
          model_eval();
          m_state = 2;
        end
      end else if (m_state == 2 && bus.res_ready) begin
        m_state = 0;
        m_cnt = 0;
        m_isi = 255;
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_res_valid", bus.res_valid, m_state == 2);
    chk("cmp_busy", bus.busy, m_state != 0);
    chk("cmp_spike_cnt", bus.spike_cnt, m_cnt);
    chk("cmp_isi_min", bus.isi_min, m_isi);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start(input int len);
    bus.win_len = 8'(len);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic accept();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  bit en_v[9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
  bit sp_v[9] = '{1, 0, 0, 1, 0, 0, 0, 1, 0};

  initial begin
    int nv;
    bus.ena = 1'b1;
    bus.spike_in = 1'b0;
    bus.win_len = '0;
    bus.start = 1'b0;
    bus.res_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_isi", bus.isi_min, 255);
    chk("rst_busy", bus.busy, 0);
    #19 rst_n = 1'b1;
    tick();

    pulse_start(10);
    for (int k = 1; k <= 10; k++) begin
      bus.spike_in = (k == 2 || k == 5 || k == 9);
      tick();
      if (k == 9) chk("t1_no_valid_c10", bus.res_valid, 0);
    end
    chk("t1_valid_c11", bus.res_valid, 1);
    chk("t1_cnt", bus.spike_cnt, 3);
    chk("t1_isi", bus.isi_min, 3);
    bus.spike_in = 1'b0;
    accept();
    chk("t1_idle", bus.busy, 0);

    bus.spike_in = 1'b1;
    tick();
    pulse_start(4);
    repeat (4) tick();
    chk("t2_valid", bus.res_valid, 1);
    chk("t2_cnt", bus.spike_cnt, 1);
    chk("t2_isi", bus.isi_min, 255);
    bus.spike_in = 1'b0;
    accept();

    pulse_start(0);
    for (int k = 1; k <= 256; k++) begin
      bus.spike_in = (k % 2) == 1;
      tick();
      if (k == 255) chk("t3_no_valid_c256", bus.res_valid, 0);
    end
    chk("t3_valid", bus.res_valid, 1);
    chk("t3_cnt", bus.spike_cnt, 128);
    chk("t3_isi", bus.isi_min, 2);
    bus.spike_in = 1'b0;
    accept();

    pulse_start(3);
    for (int k = 1; k <= 3; k++) begin
      bus.spike_in = (k == 1 || k == 3);
      tick();
    end
    bus.spike_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.start = 1'b1;
        bus.win_len = 8'd5;
      end
      tick();
      bus.start = 1'b0;
      chk("t4_hold_valid", bus.res_valid, 1);
      chk("t4_hold_cnt", bus.spike_cnt, 2);
      chk("t4_hold_isi", bus.isi_min, 2);
    end
    bus.res_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    bus.start = 1'b0;
    chk("t4_valid_drop", bus.res_valid, 0);
    chk("t4_idle", bus.busy, 0);
    tick();
    chk("t4_start_at_handshake_ignored", bus.busy, 0);

    pulse_start(6);
    for (int i = 0; i < 9; i++) begin
      bus.ena = en_v[i];
      bus.spike_in = sp_v[i];
      tick();
      if (i == 7) chk("t5_no_valid_c9", bus.res_valid, 0);
    end
    bus.ena = 1'b1;
    bus.spike_in = 1'b0;
    chk("t5_valid_c10", bus.res_valid, 1);
    chk("t5_cnt", bus.spike_cnt, 2);
    chk("t5_isi", bus.isi_min, 4);
    accept();

    pulse_start(20);
    for (int k = 1; k <= 5; k++) begin
      bus.spike_in = (k == 2);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_valid", bus.res_valid, 0);
    chk("t6_rst_cnt", bus.spike_cnt, 0);
    chk("t6_rst_isi", bus.isi_min, 255);
    tick();
    #3 rst_n = 1'b1;
    nv = 0;
    repeat (30) begin
      tick();
      if (bus.res_valid) nv++;
    end
    chk("t6_no_valid_after_reset", nv, 0);

    pulse_start(2);
    bus.spike_in = 1'b1;
    repeat (2) tick();
    bus.spike_in = 1'b0;
    chk("t7_valid", bus.res_valid, 1);
    chk("t7_cnt", bus.spike_cnt, 1);
    chk("t7_isi", bus.isi_min, 255);
    accept();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
